watch_time_core: RTL and testbench
==================================

# watch_time_core

Timekeeping and time-set datapath for the clock mode of the stopwatch/clock design. It sits directly downstream of `button_mode_s`, which provides the per-field adjust buttons. The block counts centiseconds, seconds, minutes and hours from a 100 Hz tick. It applies one-field increments from the debounced `btn_sec`, `btn_min` and `btn_hour` lines, and its outputs feed the FND display mux.

## Interface
- `TICK_DIV`, default 100: ticks per second. Centisecond counter range is 0..`TICK_DIV`-1.
- `INIT_HOUR`, default 12: hour value loaded at reset.
- `clk` input, 1 bit: system clock, 100 MHz.
- `rst` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `i_tick` input, 1 bit: 100 Hz strobe, one `clk` cycle wide.
- `btn_sec` input, 1 bit: debounced seconds-adjust level from `button_mode_s`.
- `btn_min` input, 1 bit: debounced minutes-adjust level.
- `btn_hour` input, 1 bit: debounced hours-adjust level.
- `o_msec` output, 7 bits: centiseconds, 0..`TICK_DIV`-1.
- `o_sec` output, 6 bits: seconds, 0..59.
- `o_min` output, 6 bits: minutes, 0..59.
- `o_hour` output, 5 bits: hours, 0..23.
- `o_sec_pulse` output, 1 bit: one-cycle strobe when `o_msec` wraps. Drives the display colon blink.

## Operation
- **Edge detection:** each button input is registered once. An adjust event is a rising edge (registered 0, current 1). Holding a button produces one event, except with the auto-repeat feature (see Configuration).
- **Tick chain:** on `i_tick`, msec increments.
  - msec wraps `TICK_DIV`-1→0 and carries into sec.
  - sec wraps 59→0 and carries into min.
  - min wraps 59→0 and carries into hour.
  - hour wraps 23→0 with no carry out.
- **Adjust:** an adjust event increments only its own field, modulo 60 (sec/min) or 24 (hour). It never carries into a higher field.
- **Adjust priority:** in a cycle where a field has an adjust event, that field takes the adjust increment and discards any incoming tick carry. Carry out of that field in that cycle is 0.
  - Lower fields update normally.
  - Higher fields are unaffected by the dropped carry.
- **Simultaneous buttons:** several adjust events in one cycle each apply to their own field independently.
- **Sec pulse:** `o_sec_pulse` is 1 for exactly the cycle after the msec wrap, aligned with msec = 0 on the outputs.
- **Mode gating:** no state depends on mode. Mode gating is done upstream by `button_mode_s`; in stopwatch mode all three adjust lines are 0.

## Timing
- All outputs are registered.
- Reset values: msec = 0, sec = 0, min = 0, hour = `INIT_HOUR`, `o_sec_pulse` = 0, button edge registers = 0.
- **Reset during a held button:** after `rst` deasserts with a button still high, the edge register samples 1 on the first cycle. The first post-reset cycle therefore counts as a rising edge; this is required, defined behaviour.
- **Latency, tick:** `i_tick` high at cycle N → new field values visible at N+1. The full carry ripple (msec through hour) settles in that same single cycle.
- **Latency, adjust:** a button that is first sampled high at cycle N produces the incremented field at N+1.
- **`rst` priority:** `rst` overrides both tick and adjust events in the same cycle.
- **Arithmetic:** widths are fixed by maximum value. Wrap comparisons are equality against the maximum value, never overflow.

## Configuration
- **`WATCH_AUTO_REPEAT_EN` defined:**
  - A button held continuously for 50 ticks after its rising edge enters repeat state.
  - In repeat state it generates one further adjust event every 10 ticks until released.
  - Each button has an independent 6-bit tick counter and a 2-state FSM: HOLD_WAIT → REPEAT, returning to idle on release.
  - Repeat events obey the same priority rules as edge events.
  - Releasing the button clears that counter and FSM state synchronously.
- **Not defined:** exactly one adjust event per rising edge. No repeat counters or FSMs are instantiated.

## Test plan
- **Reset:** assert `rst` for 3 cycles → msec = 0, sec = 0, min = 0, hour = 12, `o_sec_pulse` = 0.
- **Full rollover:** preload 23:59:59.99 via adjust presses, then apply one `i_tick` → next cycle reads 00:00:00.00 and `o_sec_pulse` = 1 for exactly 1 cycle.
- **Adjust wrap, no carry:** at min = 59, hour = 5, pulse `btn_min` → min = 0, hour stays 5. At hour = 23, pulse `btn_hour` → hour = 0.
- **Tick/adjust collision:** at sec = 59, msec = 99, min = 10, assert `i_tick` on the same cycle as the `btn_sec` rising edge → sec = 0 (adjust wins), msec = 0, min stays 10.
- **Held button:** hold `btn_hour` high for 200 ticks.
  - Without `WATCH_AUTO_REPEAT_EN`: hour advances exactly 1.
  - With it: hour advances 1 + 16 = 17 (repeats at ticks 50, 60 … 200).
- **Reset mid-hold:** assert `rst` while `btn_sec` is held, then release `rst` with `btn_sec` still high → sec = 1 one cycle after `rst` deasserts. Repeat counting restarts from 0.

Source files
------------

// File: rtl/watch_time_core.sv
// Clock-mode timekeeping: centisecond/second/minute/hour chain with per-field adjust buttons.
// Optional auto-repeat of held adjust buttons is enabled by defining WATCH_AUTO_REPEAT_EN.
module watch_time_core #(
  parameter int TICK_DIV  = 100,
  parameter int INIT_HOUR = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_hour,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_sec_pulse
);

  localparam logic [6:0] MSEC_MAX  = 7'(TICK_DIV - 1);
  localparam logic [4:0] HOUR_INIT = 5'(INIT_HOUR);

  // Bit 0 = sec, bit 1 = min, bit 2 = hour
  logic [2:0] btn, btn_q, edge_evt, adj_evt;

  logic [6:0] msec_q, msec_d;
  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       sec_pulse_q;
  logic       msec_wrap, sec_carry, min_carry;

  assign btn      = {btn_hour, btn_min, btn_sec};
  assign edge_evt = btn & ~btn_q;

`ifdef WATCH_AUTO_REPEAT_EN
  typedef enum logic {HOLD_WAIT, REPEAT} rpt_state_t;

  rpt_state_t rpt_state_q [3];
  rpt_state_t rpt_state_d [3];
  logic [5:0] rpt_cnt_q   [3];
  logic [5:0] rpt_cnt_d   [3];
  logic [2:0] rpt_evt;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (rst) begin
        rpt_state_q[i] <= HOLD_WAIT;
        rpt_cnt_q[i]   <= '0;
      end else begin
        rpt_state_q[i] <= rpt_state_d[i];
        rpt_cnt_q[i]   <= rpt_cnt_d[i];
      end
    end
  end

  // Released buttons park in HOLD_WAIT with a cleared count; ticks only advance held ones
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      rpt_evt[i]     = 1'b0;
      if (!btn[i]) begin
        rpt_state_d[i] = HOLD_WAIT;
        rpt_cnt_d[i]   = '0;
      end else if (i_tick) begin
        case (rpt_state_q[i])
          HOLD_WAIT: begin
            if (rpt_cnt_q[i] == 6'd49) begin
              rpt_evt[i]     = 1'b1;
              rpt_state_d[i] = REPEAT;
              rpt_cnt_d[i]   = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + 6'd1;
            end
          end
          REPEAT: begin
            if (rpt_cnt_q[i] == 6'd9) begin
              rpt_evt[i]   = 1'b1;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + 6'd1;
            end
          end
          default: begin
            rpt_state_d[i] = HOLD_WAIT;
            rpt_cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  assign adj_evt = edge_evt | rpt_evt;
`else
  assign adj_evt = edge_evt;
`endif

  // An adjusted field ignores its incoming carry and emits none in that cycle
  always_comb begin
    msec_wrap = i_tick && (msec_q == MSEC_MAX);
    msec_d    = msec_q;
    if (i_tick) msec_d = msec_wrap ? '0 : msec_q + 7'd1;

    sec_d     = sec_q;
    sec_carry = 1'b0;
    if (adj_evt[0]) begin
      sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
    end else if (msec_wrap) begin
      sec_d     = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
      sec_carry = (sec_q == 6'd59);
    end

    min_d     = min_q;
    min_carry = 1'b0;
    if (adj_evt[1]) begin
      min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
    end else if (sec_carry) begin
      min_d     = (min_q == 6'd59) ? '0 : min_q + 6'd1;
      min_carry = (min_q == 6'd59);
    end

    hour_d = hour_q;
    if (adj_evt[2] || min_carry) hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q       <= '0;
      msec_q      <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= HOUR_INIT;
      sec_pulse_q <= 1'b0;
    end else begin
      btn_q       <= btn;
      msec_q      <= msec_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_pulse_q <= msec_wrap;
    end
  end

  assign o_msec      = msec_q;
  assign o_sec       = sec_q;
  assign o_min       = min_q;
  assign o_hour      = hour_q;
  assign o_sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_watch_time_core.sv
// Vector table plus hand-written sequences for watch_time_core; expected values queued per applied cycle.
module tb_watch_time_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_tick = 1'b0;
  logic       btn_sec = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_hour = 1'b0;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_sec_pulse;

  watch_time_core #(.TICK_DIV(100), .INIT_HOUR(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (i_tick),
    .btn_sec    (btn_sec),
    .btn_min    (btn_min),
    .btn_hour   (btn_hour),
    .o_msec     (o_msec),
    .o_sec      (o_sec),
    .o_min      (o_min),
    .o_hour     (o_hour),
    .o_sec_pulse(o_sec_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ms;
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic       p;
  } exp_t;

  typedef struct {
    string name;
    logic  r, t, bs, bm, bh;
    exp_t  e;
  } vec_t;

`ifdef WATCH_AUTO_REPEAT_EN
  localparam logic [4:0] HELD_HOUR  = 5'd5;   // (12 + 1 + 16) mod 24
  localparam logic [5:0] RESTART_SEC = 6'd2;
`else
  localparam logic [4:0] HELD_HOUR  = 5'd13;
  localparam logic [5:0] RESTART_SEC = 6'd1;
`endif

  exp_t exp_q[$];
  vec_t tbl[15];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(input int ms, input int s, input int m, input int h, input int p);
    exp_t e;
    e.ms = 7'(ms); e.s = 6'(s); e.m = 6'(m); e.h = 5'(h); e.p = 1'(p);
    return e;
  endfunction

  function automatic vec_t mv(input string n, input logic r, input logic t, input logic bs,
                              input logic bm, input logic bh, input exp_t e);
    vec_t v;
    v.name = n; v.r = r; v.t = t; v.bs = bs; v.bm = bm; v.bh = bh; v.e = e;
    return v;
  endfunction

  task automatic drive(input logic r, input logic t, input logic bs, input logic bm, input logic bh);
    rst = r; i_tick = t; btn_sec = bs; btn_min = bm; btn_hour = bh;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    n_vec++;
    if (o_msec !== e.ms || o_sec !== e.s || o_min !== e.m || o_hour !== e.h || o_sec_pulse !== e.p) begin
      n_err++;
      $display("FAIL %s: got %0d:%0d:%0d.%0d pulse=%0b, want %0d:%0d:%0d.%0d pulse=%0b",
               name, o_hour, o_min, o_sec, o_msec, o_sec_pulse, e.h, e.m, e.s, e.ms, e.p);
    end
  endtask

  task automatic apply(input string name, input logic r, input logic t, input logic bs,
                       input logic bm, input logic bh, input exp_t e);
    exp_q.push_back(e);
    drive(r, t, bs, bm, bh);
    check(name);
  endtask

  // field: 0 = sec, 1 = min, 2 = hour; each press is one high cycle then one low cycle
  task automatic press(input int field, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, field == 0, field == 1, field == 2);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    tbl[0]  = mv("rst_over_tick_adj", 1, 1, 0, 0, 1, mk(0, 0, 0, 12, 0));
    tbl[1]  = mv("rst_cycle2",        1, 0, 0, 0, 0, mk(0, 0, 0, 12, 0));
    tbl[2]  = mv("rst_cycle3",        1, 0, 0, 0, 0, mk(0, 0, 0, 12, 0));
    tbl[3]  = mv("post_rst_idle",     0, 0, 0, 0, 0, mk(0, 0, 0, 12, 0));
    tbl[4]  = mv("tick1",             0, 1, 0, 0, 0, mk(1, 0, 0, 12, 0));
    tbl[5]  = mv("idle_hold",         0, 0, 0, 0, 0, mk(1, 0, 0, 12, 0));
    tbl[6]  = mv("tick2",             0, 1, 0, 0, 0, mk(2, 0, 0, 12, 0));
    tbl[7]  = mv("sec_edge",          0, 0, 1, 0, 0, mk(2, 1, 0, 12, 0));
    tbl[8]  = mv("sec_held",          0, 0, 1, 0, 0, mk(2, 1, 0, 12, 0));
    tbl[9]  = mv("sec_release",       0, 0, 0, 0, 0, mk(2, 1, 0, 12, 0));
    tbl[10] = mv("min_hour_simul",    0, 0, 0, 1, 1, mk(2, 1, 1, 13, 0));
    tbl[11] = mv("tick_plus_sec",     0, 1, 1, 0, 0, mk(3, 2, 1, 13, 0));
    tbl[12] = mv("all_released",      0, 0, 0, 0, 0, mk(3, 2, 1, 13, 0));
    tbl[13] = mv("hour_edge",         0, 0, 0, 0, 1, mk(3, 2, 1, 14, 0));
    tbl[14] = mv("hour_release",      0, 0, 0, 0, 0, mk(3, 2, 1, 14, 0));

    for (int i = 0; i < 15; i++)
      apply(tbl[i].name, tbl[i].r, tbl[i].t, tbl[i].bs, tbl[i].bm, tbl[i].bh, tbl[i].e);

    // Full rollover from 23:59:59.99
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press(2, 11);
    press(1, 59);
    press(0, 59);
    ticks(99);
    apply("preload_235959_99", 0, 0, 0, 0, 0, mk(99, 59, 59, 23, 0));
    apply("full_rollover",     0, 1, 0, 0, 0, mk(0, 0, 0, 0, 1));
    apply("pulse_one_cycle",   0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0));

    // Adjust wrap never carries
    press(2, 5);
    press(1, 59);
    apply("preload_min59_h5",  0, 0, 0, 0, 0, mk(0, 0, 59, 5, 0));
    apply("min_wrap_no_carry", 0, 0, 0, 1, 0, mk(0, 0, 0, 5, 0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    press(2, 18);
    apply("preload_h23",       0, 0, 0, 0, 0, mk(0, 0, 0, 23, 0));
    apply("hour_wrap",         0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Tick carry into sec collides with a sec adjust edge
    apply("rst_collision",     1, 0, 0, 0, 0, mk(0, 0, 0, 12, 0));
    press(1, 10);
    press(0, 59);
    ticks(99);
    apply("preload_collision", 0, 0, 0, 0, 0, mk(99, 59, 10, 12, 0));
    apply("tick_adj_collision", 0, 1, 1, 0, 0, mk(0, 0, 10, 12, 1));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Held hour button across 200 ticks
    apply("rst_held",          1, 0, 0, 0, 0, mk(0, 0, 0, 12, 0));
    apply("held_hour_edge",    0, 0, 0, 0, 1, mk(0, 0, 0, 13, 0));
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    apply("held_hour_200",     0, 0, 0, 0, 0, mk(0, 2, 0, HELD_HOUR, 0));

    // Reset while sec button is held: first post-reset cycle is an edge, repeat count restarts
    apply("rst_mid_hold1",     1, 0, 1, 0, 0, mk(0, 0, 0, 12, 0));
    apply("rst_mid_hold2",     1, 1, 1, 0, 0, mk(0, 0, 0, 12, 0));
    apply("post_rst_edge",     0, 0, 1, 0, 0, mk(0, 1, 0, 12, 0));
    for (int i = 0; i < 49; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    apply("hold_49_ticks",     0, 0, 1, 0, 0, mk(49, 1, 0, 12, 0));
    apply("hold_50th_tick",    0, 1, 1, 0, 0, mk(50, RESTART_SEC, 0, 12, 0));
    apply("hold_release",      0, 0, 0, 0, 0, mk(50, RESTART_SEC, 0, 12, 0));

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
